// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display.
// Used by calc_result_display and seg7_decoder.
`timescale 1ns/1ps
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int DIGIT_IDX_W = 2;
    localparam int NUM_DIGITS  = 4;

    // Active-low patterns, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_C     = 7'b0100111;

    // Double-dabble correction step applied before each left shift
    function automatic bcd_t bcd_adj(input bcd_t n);
        return (n >= 4'd5) ? bcd_t'(n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low 7-segment pattern (g..a); codes above 9 are blanked.
`timescale 1ns/1ps
module seg7_decoder
    import calc_disp_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Converts the calculator result to BCD (sequential double dabble) and scans four
// active-low 7-segment digits. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
`timescale 1ns/1ps
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            result,
    input  logic                  carry_out,
    input  logic                  overflow,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0] SHIFT_CNT = 4'd8;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    state_t state, state_nxt;

    logic [9:0]  snap;
    logic [9:0]  cur_in;
    logic        changed;
    logic [19:0] sreg;
    logic [19:0] sreg_adj;
    logic [3:0]  cnt;

    bcd_t disp_h, disp_t, disp_o;
    logic flag_c, flag_v;

    logic [PW-1:0]          presc;
    logic                   presc_wrap;
    logic [DIGIT_IDX_W-1:0] idx;

    logic [6:0]            dec_h, dec_t, dec_o;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign cur_in  = {result, carry_out, overflow};
    assign changed = (cur_in != snap);
    assign busy    = (state != ST_IDLE);

    assign sreg_adj = {bcd_adj(sreg[19:16]), bcd_adj(sreg[15:12]),
                       bcd_adj(sreg[11:8]), sreg[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // SHIFT holds one extra cycle once the count reaches 8, so the display
    // registers land ten edges after the change is detected.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (changed) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == SHIFT_CNT) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap   <= '0;
            sreg   <= '0;
            cnt    <= '0;
            disp_h <= '0;
            disp_t <= '0;
            disp_o <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (changed) begin
                        snap <= cur_in;
                        sreg <= {12'b0, result};
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != SHIFT_CNT) begin
                        sreg <= {sreg_adj[18:0], 1'b0};
                        cnt  <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    disp_h <= sreg[19:16];
                    disp_t <= sreg[15:12];
                    disp_o <= sreg[11:8];
                    flag_c <= snap[1];
                    flag_v <= snap[0];
                end
                default: ;
            endcase
        end
    end

    assign presc_wrap = (presc == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
            idx   <= idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    seg7_decoder u_dec_h (.bcd(disp_h), .seg(dec_h));
    seg7_decoder u_dec_t (.bcd(disp_t), .seg(dec_t));
    seg7_decoder u_dec_o (.bcd(disp_o), .seg(dec_o));

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        an_nxt  = ~(AN_ONE << idx);
        case (idx)
            2'd0: seg_nxt = dec_o;
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (disp_h == 4'd0 && disp_t == 4'd0) seg_nxt = SEG_BLANK;
                else                                  seg_nxt = dec_t;
`else
                seg_nxt = dec_t;
`endif
            end
            2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (disp_h == 4'd0) seg_nxt = SEG_BLANK;
                else                seg_nxt = dec_h;
`else
                seg_nxt = dec_h;
`endif
            end
            default: begin
                if (flag_v)      seg_nxt = SEG_O;
                else if (flag_c) seg_nxt = SEG_C;
                else             seg_nxt = SEG_BLANK;
                dp_nxt = ~(flag_c & flag_v);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display with REFRESH_DIV=4.
// Expected displays are queued when a result is driven and checked after each conversion.
`timescale 1ns/1ps
module tb_calc_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    typedef struct packed {
        logic [7:0] val;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    calc_result_display #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result   (result),
        .carry_out(carry_out),
        .overflow (overflow),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .busy     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input exp_t e, input int i);
        int h;
        int t;
        int o;
        h = int'(e.val) / 100;
        t = (int'(e.val) / 10) % 10;
        o = int'(e.val) % 10;
        case (i)
            0: return seg_of(o);
            1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (h == 0 && t == 0) return 7'b1111111;
`endif
                return seg_of(t);
            end
            2: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (h == 0) return 7'b1111111;
`endif
                return seg_of(h);
            end
            default: begin
                if (e.v)      return 7'b0100011;
                else if (e.c) return 7'b0100111;
                else          return 7'b1111111;
            end
        endcase
    endfunction

    function automatic int idx_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Compare each digit the first time it is selected within the window.
    task automatic check_disp(input exp_t e, input int ncyc, input string tag);
        bit seen [4];
        int nseen;
        int i;
        nseen = 0;
        foreach (seen[k]) seen[k] = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            i = idx_of(an);
            if (i >= 0 && !seen[i]) begin
                seen[i] = 1'b1;
                nseen++;
                check_val($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp_seg(e, i)));
                check_val($sformatf("%s_dp%0d", tag, i), 32'(dp),
                          (i == 3 && e.c && e.v) ? 32'd0 : 32'd1);
            end
        end
        if (ncyc >= 16) check_val({tag, "_digits_seen"}, 32'(nseen), 32'd4);
    endtask

    task automatic run_conv(input string tag, output int hi_cyc);
        int guard;
        guard  = 0;
        hi_cyc = 0;
        while (!busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
        guard = 0;
        while (busy && guard < 40) begin
            hi_cyc++;
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic finish_conv(input int ncyc, input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_disp(e, ncyc, tag);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic c, input logic v);
        result    = r;
        carry_out = c;
        overflow  = v;
        sb_q.push_back('{val: r, c: c, v: v});
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_seg"},  32'(seg),  32'h7F);
        check_val({tag, "_dp"},   32'(dp),   32'd1);
        check_val({tag, "_an"},   32'(an),   32'hF);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an_seq [4];
        logic [3:0] an_prev;
        int         n_seq;
        bit         busy_seen;
        int         hc;

        rst_n     = 1'b0;
        result    = 8'd0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;

        // Idle at zero: no conversion, scan order and 000/blank display
        an_prev   = 4'hF;
        n_seq     = 0;
        busy_seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (an != an_prev && n_seq < 4) begin
                an_seq[n_seq] = an;
                n_seq++;
            end
            an_prev = an;
        end
        check_val("idle_busy_seen", 32'(busy_seen), 32'd0);
        check_val("scan_n", 32'(n_seq), 32'd4);
        check_val("scan_an0", 32'(an_seq[0]), 32'b1110);
        check_val("scan_an1", 32'(an_seq[1]), 32'b1101);
        check_val("scan_an2", 32'(an_seq[2]), 32'b1011);
        check_val("scan_an3", 32'(an_seq[3]), 32'b0111);
        check_disp('{val: 8'd0, c: 1'b0, v: 1'b0}, 20, "zero");

        // 255: conversion length and all-nonzero digits
        drive(8'd255, 1'b0, 1'b0);
        run_conv("r255", hc);
        check_val("r255_busy_len", 32'(hc), 32'd10);
        finish_conv(20, "r255");

        // Both flags set: status "o" with decimal point
        drive(8'd7, 1'b1, 1'b1);
        run_conv("r7", hc);
        check_val("r7_busy_len", 32'(hc), 32'd10);
        finish_conv(20, "r7");

        // Carry only: status "c"
        drive(8'd80, 1'b1, 1'b0);
        run_conv("r80", hc);
        finish_conv(20, "r80");

        // Input change mid-conversion is deferred to a second conversion
        drive(8'd12, 1'b0, 1'b0);
        run_conv_rise_only();
        repeat (2) @(negedge clk);
        drive(8'd200, 1'b0, 1'b0);
        run_conv("r12", hc);
        finish_conv(10, "r12");
        run_conv("r200", hc);
        finish_conv(20, "r200");

        // Reset asserted mid-SHIFT
        result = 8'd99;
        run_conv_rise_only();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        check_reset_outs("midrst_hold");
        rst_n = 1'b1;
        sb_q.push_back('{val: 8'd99, c: 1'b0, v: 1'b0});
        run_conv("r99", hc);
        finish_conv(20, "r99");

        // Leading-zero cases
        drive(8'd5, 1'b0, 1'b0);
        run_conv("r5", hc);
        finish_conv(20, "r5");
        drive(8'd105, 1'b0, 1'b0);
        run_conv("r105", hc);
        finish_conv(20, "r105");

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic run_conv_rise_only();
        int guard;
        guard = 0;
        while (!busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("busy_rise_only", 32'(busy), 32'd1);
    endtask

endmodule
